knn_class_voter: RTL

- Sequential, parametrised majority voter for the KNN accelerator; successor to the fixed 5-neighbour, 2-class group decider.
- Accepts K neighbour class labels over a valid/ready stream, one label per cycle, and counts the votes per class.
- Scans the counters for the winning class and presents it on a valid/ready result port with vote count and tie flag.
- Sits between the K-smallest-distance sorter and the classification result register.

---
 rtl/knn_class_voter_pkg.sv | 19 +
 rtl/knn_class_voter_if.sv | 30 +++
 rtl/knn_vote_counter_bank.sv | 47 ++++
 rtl/knn_class_voter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/knn_class_voter_pkg.sv
// Shared types and constants for the KNN voter and sorter.
// Widths for labels and vote counters come from clog2_min1 so that K=1 still yields one bit.
package knn_pkg;

  localparam int unsigned KNN_K           = 5;
  localparam int unsigned KNN_NUM_CLASSES = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } voter_state_e;

  // ceil(log2(n)), never less than 1
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_class_voter_if.sv
// Label stream and result port of the KNN class voter.
// The slave modport is the voter side; the master modport is the sorter/result-register side.
interface knn_class_voter_if #(
  parameter int unsigned K           = knn_pkg::KNN_K,
  parameter int unsigned NUM_CLASSES = knn_pkg::KNN_NUM_CLASSES
);
  localparam int unsigned CLASS_W = knn_pkg::clog2_min1(NUM_CLASSES);
  localparam int unsigned CNT_W   = knn_pkg::clog2_min1(K + 1);

  logic               i_label_valid;
  logic               o_label_ready;
  logic [CLASS_W-1:0] i_label;
  logic               o_group_valid;
  logic               i_group_ready;
  logic [CLASS_W-1:0] o_group;
  logic [CNT_W-1:0]   o_votes;
  logic               o_tie;
  logic               o_bad_label;

  modport slave (
    input  i_label_valid, i_label, i_group_ready,
    output o_label_ready, o_group_valid, o_group, o_votes, o_tie, o_bad_label
  );

  modport master (
    output i_label_valid, i_label, i_group_ready,
    input  o_label_ready, o_group_valid, o_group, o_votes, o_tie, o_bad_label
  );

endinterface

// File: rtl/knn_vote_counter_bank.sv
// NUM_CLASSES saturating vote counters with one increment port, a bulk clear
// and a combinational read port selected by index (out-of-range index reads 0).
module knn_vote_counter_bank #(
  parameter int unsigned K           = knn_pkg::KNN_K,
  parameter int unsigned NUM_CLASSES = knn_pkg::KNN_NUM_CLASSES
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_inc,
  input  logic [knn_pkg::clog2_min1(NUM_CLASSES)-1:0]  i_inc_idx,
  input  logic                                          i_clr,
  input  logic [knn_pkg::clog2_min1(NUM_CLASSES)-1:0]  i_rd_idx,
  output logic [knn_pkg::clog2_min1(K+1)-1:0]          o_rd_cnt_c
);
  import knn_pkg::*;

  localparam int unsigned CLASS_W = clog2_min1(NUM_CLASSES);
  localparam int unsigned CNT_W   = clog2_min1(K + 1);

  logic [CNT_W-1:0] r_cnt [NUM_CLASSES];
  logic [CNT_W-1:0] w_rd_cnt;

  // Count votes, saturating at K; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) r_cnt[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) r_cnt[i] <= '0;
    end else if (i_inc) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        if (i_inc_idx == CLASS_W'(i) && r_cnt[i] != CNT_W'(K))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Read mux by index
  always_comb begin
    w_rd_cnt = '0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if (i_rd_idx == CLASS_W'(i)) w_rd_cnt = r_cnt[i];
    end
  end

  assign o_rd_cnt_c = w_rd_cnt;

endmodule

// File: rtl/knn_class_voter.sv
// KNN majority voter: collects K class labels, scans the per-class vote
// counters for the winner and offers it on a valid/ready result port.
// Optional: define KNN_VOTER_NEAREST_TIEBREAK_EN to break ties in favour of
// the nearest neighbour's class instead of the lowest class index.
module knn_class_voter
  import knn_pkg::*;
#(
  parameter int unsigned K           = KNN_K,
  parameter int unsigned NUM_CLASSES = KNN_NUM_CLASSES
) (
  input logic               clk,
  input logic               rst,
  knn_class_voter_if.slave  bus
);

  localparam int unsigned CLASS_W = clog2_min1(NUM_CLASSES);
  localparam int unsigned CNT_W   = clog2_min1(K + 1);

  voter_state_e       r_state;
  voter_state_e       w_next_state;

  logic [CNT_W-1:0]   r_lbl_cnt;
  logic [CLASS_W-1:0] r_scan_idx;
  logic [CLASS_W-1:0] r_best;
  logic [CNT_W-1:0]   r_best_cnt;
  logic               r_tie;
  logic               r_bad;

  logic               r_label_ready;
  logic               r_group_valid;
  logic [CLASS_W-1:0] r_group;
  logic [CNT_W-1:0]   r_votes;
  logic               r_out_tie;
  logic               r_out_bad;

  logic               w_accept;
  logic               w_in_range;
  logic               w_inc;
  logic               w_clr;
  logic               w_fire;
  logic               w_scan_last;
  logic [CLASS_W-1:0] w_rd_idx;
  logic [CNT_W-1:0]   w_rd_cnt;
  logic [CLASS_W-1:0] w_win_group;

  assign w_in_range  = (32'(bus.i_label) < NUM_CLASSES);
  assign w_scan_last = (r_scan_idx == CLASS_W'(NUM_CLASSES - 1));

`ifdef KNN_VOTER_NEAREST_TIEBREAK_EN
  logic [CLASS_W-1:0] r_first_label;
  logic               w_pick_first;

  // In DONE the read port looks up the nearest neighbour's class count
  assign w_rd_idx     = (r_state == DONE) ? r_first_label : r_scan_idx;
  assign w_pick_first = r_tie && (32'(r_first_label) < NUM_CLASSES) && (w_rd_cnt == r_best_cnt);
  assign w_win_group  = w_pick_first ? r_first_label : r_best;

  // Remember the first label of each round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_label <= '0;
    end else if (r_state == COLLECT && w_accept && r_lbl_cnt == '0) begin
      r_first_label <= bus.i_label;
    end
  end
`else
  assign w_rd_idx    = r_scan_idx;
  assign w_win_group = r_best;
`endif

  knn_vote_counter_bank #(
    .K           (K),
    .NUM_CLASSES (NUM_CLASSES)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_inc),
    .i_inc_idx  (bus.i_label),
    .i_clr      (w_clr),
    .i_rd_idx   (w_rd_idx),
    .o_rd_cnt_c (w_rd_cnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_inc        = 1'b0;
    w_clr        = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      COLLECT: begin
        w_accept = bus.i_label_valid && r_label_ready;
        w_inc    = w_accept && w_in_range;
        if (w_accept && r_lbl_cnt == CNT_W'(K - 1)) w_next_state = SCAN;
      end
      SCAN: begin
        if (w_scan_last) w_next_state = DONE;
      end
      DONE: begin
        w_fire = r_group_valid && bus.i_group_ready;
        if (w_fire) begin
          w_clr        = 1'b1;
          w_next_state = COLLECT;
        end
      end
      default: w_next_state = COLLECT;
    endcase
  end

  // Label counting, winner scan and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lbl_cnt     <= '0;
      r_scan_idx    <= '0;
      r_best        <= '0;
      r_best_cnt    <= '0;
      r_tie         <= 1'b0;
      r_bad         <= 1'b0;
      r_label_ready <= 1'b1;
      r_group_valid <= 1'b0;
      r_group       <= '0;
      r_votes       <= '0;
      r_out_tie     <= 1'b0;
      r_out_bad     <= 1'b0;
    end else begin
      r_label_ready <= (w_next_state == COLLECT);
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_lbl_cnt <= r_lbl_cnt + CNT_W'(1);
            if (!w_in_range) r_bad <= 1'b1;
          end
        end
        SCAN: begin
          r_scan_idx <= w_scan_last ? '0 : r_scan_idx + CLASS_W'(1);
          if (w_rd_cnt > r_best_cnt) begin
            r_best     <= r_scan_idx;
            r_best_cnt <= w_rd_cnt;
            r_tie      <= 1'b0;
          end else if (w_rd_cnt == r_best_cnt) begin
            r_tie <= 1'b1;
          end
        end
        DONE: begin
          if (!r_group_valid) begin
            r_group_valid <= 1'b1;
            r_group       <= w_win_group;
            r_votes       <= r_best_cnt;
            r_out_tie     <= r_tie;
            r_out_bad     <= r_bad;
          end else if (w_fire) begin
            r_group_valid <= 1'b0;
            r_lbl_cnt     <= '0;
            r_scan_idx    <= '0;
            r_best        <= '0;
            r_best_cnt    <= '0;
            r_tie         <= 1'b0;
            r_bad         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_label_ready = r_label_ready;
  assign bus.o_group_valid = r_group_valid;
  assign bus.o_group       = r_group;
  assign bus.o_votes       = r_votes;
  assign bus.o_tie         = r_out_tie;
  assign bus.o_bad_label   = r_out_bad;

endmodule
